// File: rtl/question_reader_pkg.sv
// Shared definitions for the question reader.
// Holds the question entry field layout, the mode_sel code that enables the
// block, the FSM state encoding, default bank geometry and small helpers.
package question_reader_pkg;

  localparam int QR_N_Q = 50;
  localparam int QR_Q_W = 21;

  // Field offsets inside one question entry
  localparam int MODE_LSB = 18;
  localparam int OP_LSB   = 16;
  localparam int A_LSB    = 8;
  localparam int B_LSB    = 0;

  localparam logic [2:0] MODE_SEL_QR = 3'b010;  // block active code
  localparam logic [2:0] MODE_SKIP   = 3'b000;  // unwritten/skipped slot

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } question_t;

  function automatic question_t decode_q(input logic [20:0] e);
    question_t q;
    q.mode = e[MODE_LSB +: 3];
    q.op   = e[OP_LSB +: 2];
    q.a    = e[A_LSB +: 8];
    q.b    = e[B_LSB +: 8];
    return q;
  endfunction

  // Score counter saturates instead of wrapping
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/question_reader_btn_edge.sv
// btn_edge: rising-edge detector for one debounced button level.
// Ports: clk_i, rst_i (async, active-high), level_i (button level),
//        rise_o (one-cycle pulse, registered, one cycle after the edge).
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level_i;
      rise_q <= level_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/question_reader.sv
// question_reader: steps through a packed question bank, shows each question,
// collects the contestant answer, hands it to the judge and keeps the score.
// Inputs : clk, reset (async, active-high), mode_sel (active at 3'b010),
//          confirm/select/exit button levels, in (answer switches),
//          q_flat/q_total (question bank), ref_valid/ref_result (golden answer).
// Outputs: q_mode/q_op/q_a/q_b/q_valid (current question), ans_req/ans_out
//          (answer to the judge), q_index, score, time_left, correct, done.
module question_reader
  import question_reader_pkg::*;
#(
  parameter int N_Q      = QR_N_Q,
  parameter int Q_W      = QR_Q_W,
  parameter int TICK_DIV = 100000000,
  parameter int T_LIMIT  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode_sel,
  input  logic             confirm,
  input  logic             select,
  input  logic             exit,
  input  logic [7:0]       in,
  input  logic [N_Q*Q_W-1:0] q_flat,
  input  logic [5:0]       q_total,
  input  logic             ref_valid,
  input  logic [7:0]       ref_result,
  output logic [2:0]       q_mode,
  output logic [1:0]       q_op,
  output logic [7:0]       q_a,
  output logic [7:0]       q_b,
  output logic             q_valid,
  output logic             ans_req,
  output logic [7:0]       ans_out,
  output logic [5:0]       q_index,
  output logic [5:0]       score,
  output logic [4:0]       time_left,
  output logic             correct,
  output logic             done
);

  localparam logic [5:0]  NQ6       = 6'(N_Q);
  localparam logic [4:0]  T_INIT    = 5'(T_LIMIT);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  logic confirm_rise, select_rise, exit_rise;

  btn_edge u_confirm (.clk_i(clk), .rst_i(reset), .level_i(confirm), .rise_o(confirm_rise));
  btn_edge u_select  (.clk_i(clk), .rst_i(reset), .level_i(select),  .rise_o(select_rise));
  btn_edge u_exit    (.clk_i(clk), .rst_i(reset), .level_i(exit),    .rise_o(exit_rise));

  // select has no function in any state; its detector exists for the panel
  logic unused_select;
  assign unused_select = select_rise;

  logic [2:0]  state_q, state_d;
  logic [5:0]  q_index_q, q_index_d;
  logic [5:0]  score_q, score_d;
  logic [4:0]  time_left_q, time_left_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  ans_q, ans_d;
  logic        correct_q, correct_d;
  question_t   cur_q, cur_d;

  logic [5:0]     q_total_c;
  logic           last;
  logic [Q_W-1:0] slot;
  question_t      fetched;

  assign q_total_c = (q_total > NQ6) ? NQ6 : q_total;
  assign last      = (q_index_q == q_total_c - 6'd1);

  // Slot select as a compare-mux so an index past the bank never reads X
  always_comb begin
    slot = '0;
    for (int i = 0; i < N_Q; i++) begin
      if (q_index_q == 6'(i)) slot = q_flat[i*Q_W +: Q_W];
    end
  end

  assign fetched = decode_q(slot[20:0]);

  always_comb begin
    state_d     = state_q;
    q_index_d   = q_index_q;
    score_d     = score_q;
    time_left_d = time_left_q;
    tick_d      = tick_q;
    ans_d       = ans_q;
    correct_d   = correct_q;
    cur_d       = cur_q;
    // Outside the active mode everything freezes, timer included
    if (mode_sel == MODE_SEL_QR) begin
      if (exit_rise) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (confirm_rise) begin
              if (q_total_c != 6'd0) begin
                score_d   = 6'd0;
                q_index_d = 6'd0;
                state_d   = ST_FETCH;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
          ST_FETCH: begin
            if (fetched.mode == MODE_SKIP) begin
              if (last) state_d = ST_DONE;
              else      q_index_d = q_index_q + 6'd1;
            end else begin
              cur_d       = fetched;
              time_left_d = T_INIT;
              tick_d      = '0;
              state_d     = ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              if (time_left_q != 5'd0) time_left_d = time_left_q - 5'd1;
            end else begin
              tick_d = tick_q + 32'd1;
            end
            // An answer on the final tick still counts
            if (confirm_rise) begin
              ans_d   = in;
              state_d = ST_WAIT;
            end else if (tick_q == TICK_LAST && time_left_q <= 5'd1) begin
              ans_d     = 8'd0;
              correct_d = 1'b0;
              state_d   = ST_RESULT;
            end
          end
          ST_WAIT: begin
            if (ref_valid) begin
              correct_d = (ans_q == ref_result);
              if (ans_q == ref_result) score_d = sat_inc6(score_q);
              state_d = ST_RESULT;
            end
          end
          ST_RESULT: begin
            if (confirm_rise) begin
              if (last) begin
                state_d = ST_DONE;
              end else begin
                q_index_d = q_index_q + 6'd1;
                state_d   = ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            if (confirm_rise) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      q_index_q   <= '0;
      score_q     <= '0;
      time_left_q <= '0;
      tick_q      <= '0;
      ans_q       <= '0;
      correct_q   <= 1'b0;
      cur_q       <= '0;
    end else begin
      state_q     <= state_d;
      q_index_q   <= q_index_d;
      score_q     <= score_d;
      time_left_q <= time_left_d;
      tick_q      <= tick_d;
      ans_q       <= ans_d;
      correct_q   <= correct_d;
      cur_q       <= cur_d;
    end
  end

  assign q_mode    = cur_q.mode;
  assign q_op      = cur_q.op;
  assign q_a       = cur_q.a;
  assign q_b       = cur_q.b;
  assign q_valid   = (state_q == ST_SHOW);
  assign ans_req   = (state_q == ST_WAIT);
  assign ans_out   = ans_q;
  assign q_index   = q_index_q;
  assign score     = score_q;
  assign time_left = time_left_q;
  assign correct   = correct_q;
  assign done      = (state_q == ST_DONE);

endmodule
